// File: rtl/mul_sched.sv
// mul_sched: two-requester round-robin scheduler that sequences a shift-add
// multiplier datapath through load, execute and capture phases. An execute
// phase that runs for TIMEOUT cycles is aborted and reported with err.
module mul_sched #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        err,
    output logic        busy,
    output logic        ldA,
    output logic        ldB,
    output logic        ldP,
    output logic        clrP,
    output logic        decB,
    output logic [15:0] data_out,
    input  logic        eqz,
    input  logic [15:0] p_in
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LDA, LDB, EXEC, CAPT} state_t;

    state_t        state, state_nx;
    logic          prio1;      // requester 1 wins the next tie
    logic          sel;        // requester owning the running job
    logic [15:0]   a_q, b_q;
    logic [CW-1:0] cnt;
    logic          err_flag;
    logic          any_req, win1;

    // Round-robin pick: a lone request always wins, a tie goes to prio1.
    always_comb begin
        any_req = req0 | req1;
        win1    = req1 & (~req0 | prio1);
    end

    // State, operand latches, arbitration pointer, EXEC counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio1    <= 1'b0;
            sel      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any_req) begin
                    sel   <= win1;
                    prio1 <= ~win1;
                    a_q   <= win1 ? a1 : a0;
                    b_q   <= win1 ? b1 : b0;
                end
                EXEC: if (!eqz) begin
                    if (cnt == TMAX) err_flag <= 1'b1;
                    else             cnt      <= cnt + 1'b1;
                end
                CAPT: begin
                    result   <= p_in;
                    err_flag <= 1'b0;
                    cnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore/Mealy strobes; everything held low while in reset.
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err      = 1'b0;
        busy     = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        ldP      = 1'b0;
        clrP     = 1'b0;
        decB     = 1'b0;
        data_out = '0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: if (any_req) begin
                    gnt0     = ~win1;
                    gnt1     = win1;
                    state_nx = LDA;
                end
                LDA: begin
                    data_out = a_q;
                    ldA      = 1'b1;
                    state_nx = LDB;
                end
                LDB: begin
                    data_out = b_q;
                    ldB      = 1'b1;
                    clrP     = 1'b1;
                    state_nx = EXEC;
                end
                EXEC: begin
                    if (eqz || cnt == TMAX) begin
                        state_nx = CAPT;
                    end else begin
                        ldP  = 1'b1;
                        decB = 1'b1;
                    end
                end
                CAPT: begin
                    done0    = ~sel;
                    done1    = sel;
                    err      = err_flag;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
